// File: rtl/snax_acc_offload_arbiter.sv
// ---------------------------------------------------------------------------
// snax_acc_offload_arbiter
//
// Shares one Snitch accelerator offload port (acc q/p channels) between
// NumReq requesters. Each issued request is tagged with the index of the
// requester that won arbitration. The requester's own id is parked in a
// per-requester FIFO so that it can be restored when the matching response
// comes back. Responses are steered back by tag. A per-requester outstanding
// limit keeps any single requester from flooding the accelerator.
//
// Optional feature macro: SNAX_ACC_ARB_PERF_EN
//   When defined, per-requester 32-bit saturating stall counters are built.
//   When undefined, stall_cnt_o is tied to zero and no counter flops exist.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_valid_i       per-requester request valid
//   req_ready_o       per-requester request ready
//   req_id_i          per-requester local id
//   req_payload_i     per-requester opaque payload (addr, data_op, arga..c)
//   acc_qvalid_o      shared request valid
//   acc_qready_i      shared request ready
//   acc_qid_o         request tag (granted index, zero-extended)
//   acc_qpayload_o    payload of the granted requester
//   acc_pvalid_i      response valid
//   acc_pready_o      response ready
//   acc_pid_i         response tag
//   acc_pdata_i       response data
//   acc_perror_i      response error flag
//   rsp_valid_o       per-requester routed response valid
//   rsp_ready_i       per-requester routed response ready
//   rsp_id_o          restored original id (shared bus)
//   rsp_data_o        response data (shared bus)
//   rsp_error_o       response error (shared bus)
//   err_o             sticky protocol error (bad tag / unexpected response)
//   stall_cnt_o       per-requester stall counters
// ---------------------------------------------------------------------------
module snax_acc_offload_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned PayloadWidth   = 32+32+32+48+32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq-1:0][IdWidth-1:0]       req_id_i,
  input  logic [NumReq-1:0][PayloadWidth-1:0]  req_payload_i,
  output logic                                 acc_qvalid_o,
  input  logic                                 acc_qready_i,
  output logic [IdWidth-1:0]                   acc_qid_o,
  output logic [PayloadWidth-1:0]              acc_qpayload_o,
  input  logic                                 acc_pvalid_i,
  output logic                                 acc_pready_o,
  input  logic [IdWidth-1:0]                   acc_pid_i,
  input  logic [DataWidth-1:0]                 acc_pdata_i,
  input  logic                                 acc_perror_i,
  output logic [NumReq-1:0]                    rsp_valid_o,
  input  logic [NumReq-1:0]                    rsp_ready_i,
  output logic [IdWidth-1:0]                   rsp_id_o,
  output logic [DataWidth-1:0]                 rsp_data_o,
  output logic                                 rsp_error_o,
  output logic                                 err_o,
  output logic [NumReq-1:0][31:0]              stall_cnt_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0]              r_rr_ptr;
  logic                         r_lock;
  logic [IdxW-1:0]              r_lock_idx;
  logic                         r_err;
  logic [NumReq-1:0][CntW-1:0]  r_out_cnt;
  logic [NumReq-1:0][PtrW-1:0]  r_wr_ptr;
  logic [NumReq-1:0][PtrW-1:0]  r_rd_ptr;
  logic [IdWidth-1:0]           r_id_fifo [NumReq][MaxOutstanding];

  logic [NumReq-1:0]            w_elig;
  logic                         w_found;
  logic [IdxW-1:0]              w_rr_idx;
  logic [IdxW-1:0]              w_grant_idx;
  logic                         w_qvalid;
  logic [NumReq-1:0]            w_push;
  logic [NumReq-1:0]            w_pop;
  logic [IdxW-1:0]              w_pidx;
  logic                         w_ptag_oor;
  logic [CntW-1:0]              w_pcnt;
  logic [IdWidth-1:0]           w_phead;
  logic                         w_psel_ready;
  logic                         w_pbad;

  // FIFO pointers wrap at MaxOutstanding; written out explicitly so a depth
  // of one also works.
  function automatic logic [PtrW-1:0] ptrNext(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // A requester may compete only while it still has room for another
  // in-flight request.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NumReq; i++) begin
      w_elig[i] = req_valid_i[i] & (r_out_cnt[i] < CntW'(MaxOutstanding));
    end
  end

  // Round-robin search: walk the requesters starting at r_rr_ptr and take
  // the first eligible one.
  always_comb begin : arbSearch
    int cand;
    cand     = 0;
    w_found  = 1'b0;
    w_rr_idx = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = int'(r_rr_ptr) + k;
      if (cand >= int'(NumReq)) cand = cand - int'(NumReq);
      if (!w_found && w_elig[cand]) begin
        w_found  = 1'b1;
        w_rr_idx = IdxW'(cand);
      end
    end
  end

  // While a request is stalled by acc_qready_i the grant stays with the
  // locked requester, so the tag and payload on the q channel cannot change
  // under the accelerator's feet even if another requester shows up.
  always_comb begin
    w_grant_idx    = r_lock ? r_lock_idx : w_rr_idx;
    w_qvalid       = r_lock ? w_elig[r_lock_idx] : w_found;
    acc_qvalid_o   = w_qvalid;
    acc_qid_o      = IdWidth'(w_grant_idx);
    acc_qpayload_o = req_payload_i[w_grant_idx];
    req_ready_o    = '0;
    w_push         = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = w_qvalid & (w_grant_idx == IdxW'(i)) & acc_qready_i;
      w_push[i]      = req_ready_o[i];
    end
  end

  // Response steering. A tag outside the requester range, or one that names
  // a requester with nothing in flight, is swallowed (ready forced high) and
  // flagged; it never reaches any requester.
  always_comb begin
    w_pidx       = acc_pid_i[IdxW-1:0];
    w_ptag_oor   = ({1'b0, acc_pid_i} >= (IdWidth+1)'(NumReq));
    w_pcnt       = '0;
    w_phead      = '0;
    w_psel_ready = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!w_ptag_oor && (w_pidx == IdxW'(i))) begin
        w_pcnt       = r_out_cnt[i];
        w_phead      = r_id_fifo[i][r_rd_ptr[i]];
        w_psel_ready = rsp_ready_i[i];
      end
    end
    w_pbad       = w_ptag_oor | (w_pcnt == '0);
    acc_pready_o = w_pbad ? 1'b1 : w_psel_ready;
    rsp_id_o     = w_phead;
    rsp_data_o   = acc_pdata_i;
    rsp_error_o  = acc_perror_i;
    rsp_valid_o  = '0;
    w_pop        = '0;
    for (int i = 0; i < NumReq; i++) begin
      rsp_valid_o[i] = acc_pvalid_i & ~w_pbad & (w_pidx == IdxW'(i));
      w_pop[i]       = rsp_valid_o[i] & rsp_ready_i[i];
    end
  end

  // Arbitration state, outstanding counters, FIFO pointers and the sticky
  // error flag. A push and pop on the same requester in one cycle cancel in
  // the counter but still move both FIFO pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_err      <= 1'b0;
      r_out_cnt  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_qvalid && acc_qready_i) begin
        r_rr_ptr <= (w_grant_idx == IdxW'(NumReq - 1)) ? '0 : w_grant_idx + 1'b1;
      end
      r_lock     <= w_qvalid & ~acc_qready_i;
      r_lock_idx <= w_grant_idx;
      if (acc_pvalid_i && w_pbad) begin
        r_err <= 1'b1;
      end
      for (int i = 0; i < NumReq; i++) begin
        if (w_push[i] && !w_pop[i]) begin
          r_out_cnt[i] <= r_out_cnt[i] + 1'b1;
        end else if (!w_push[i] && w_pop[i]) begin
          r_out_cnt[i] <= r_out_cnt[i] - 1'b1;
        end
        if (w_push[i]) r_wr_ptr[i] <= ptrNext(r_wr_ptr[i]);
        if (w_pop[i])  r_rd_ptr[i] <= ptrNext(r_rd_ptr[i]);
      end
    end
  end

  // FIFO storage needs no reset: the pointers and counters define which
  // entries are live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumReq; i++) begin
      if (w_push[i]) begin
        r_id_fifo[i][r_wr_ptr[i]] <= req_id_i[i];
      end
    end
  end

  assign err_o = r_err;

`ifdef SNAX_ACC_ARB_PERF_EN
  logic [NumReq-1:0][31:0] r_stall_cnt;

  // Count every cycle a requester wants to issue but is not accepted,
  // saturating instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (req_valid_i[i] && !req_ready_o[i] && (r_stall_cnt[i] != 32'hFFFF_FFFF)) begin
          r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_snax_acc_offload_arbiter.sv
// ---------------------------------------------------------------------------
// tb_snax_acc_offload_arbiter
//
// Directed bench for snax_acc_offload_arbiter with NumReq=2, MaxOutstanding=4.
// Inputs are driven just after a rising edge; outputs are sampled 1ns later,
// well away from the next edge.
// ---------------------------------------------------------------------------
module tb_snax_acc_offload_arbiter;

  localparam int NumReq  = 2;
  localparam int IdWidth = 5;
  localparam int PW      = 176;
  localparam int DW      = 32;
  localparam int MaxOut  = 4;

  localparam logic [PW-1:0] PayloadA = {11{16'hA5C3}};
  localparam logic [PW-1:0] PayloadB = {11{16'h3C5A}};
  localparam logic [PW-1:0] Payload1 = {11{16'h1234}};

  logic                            clk_i = 1'b0;
  logic                            rst_i;
  logic [NumReq-1:0]               req_valid_i;
  logic [NumReq-1:0]               req_ready_o;
  logic [NumReq-1:0][IdWidth-1:0]  req_id_i;
  logic [NumReq-1:0][PW-1:0]       req_payload_i;
  logic                            acc_qvalid_o;
  logic                            acc_qready_i;
  logic [IdWidth-1:0]              acc_qid_o;
  logic [PW-1:0]                   acc_qpayload_o;
  logic                            acc_pvalid_i;
  logic                            acc_pready_o;
  logic [IdWidth-1:0]              acc_pid_i;
  logic [DW-1:0]                   acc_pdata_i;
  logic                            acc_perror_i;
  logic [NumReq-1:0]               rsp_valid_o;
  logic [NumReq-1:0]               rsp_ready_i;
  logic [IdWidth-1:0]              rsp_id_o;
  logic [DW-1:0]                   rsp_data_o;
  logic                            rsp_error_o;
  logic                            err_o;
  logic [NumReq-1:0][31:0]         stall_cnt_o;

  int checkCount = 0;
  int passCount  = 0;
  int grants0;
  int grants1;
  logic [31:0] stallExp;

  always #5 clk_i = ~clk_i;

  snax_acc_offload_arbiter #(
    .NumReq(NumReq), .IdWidth(IdWidth), .PayloadWidth(PW),
    .DataWidth(DW), .MaxOutstanding(MaxOut)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_id_i(req_id_i), .req_payload_i(req_payload_i),
    .acc_qvalid_o(acc_qvalid_o), .acc_qready_i(acc_qready_i),
    .acc_qid_o(acc_qid_o), .acc_qpayload_o(acc_qpayload_o),
    .acc_pvalid_i(acc_pvalid_i), .acc_pready_o(acc_pready_o),
    .acc_pid_i(acc_pid_i), .acc_pdata_i(acc_pdata_i), .acc_perror_i(acc_perror_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o),
    .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  // One comparison: count it, and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [PW-1:0] observed,
                             input logic [PW-1:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Drive the control inputs for one cycle and let combinational paths settle.
  task automatic applyStimulus(input logic [NumReq-1:0] valid, input logic qready,
                               input logic pvalid, input logic [IdWidth-1:0] pid,
                               input logic [NumReq-1:0] rspReady);
    req_valid_i  = valid;
    acc_qready_i = qready;
    acc_pvalid_i = pvalid;
    acc_pid_i    = pid;
    rsp_ready_i  = rspReady;
    #1;
  endtask

  task automatic doReset();
    applyStimulus('0, 1'b0, 1'b0, '0, '0);
    rst_i = 1'b1;
    nextCycle();
    nextCycle();
    rst_i = 1'b0;
  endtask

  initial begin
    req_id_i      = '0;
    req_payload_i = '0;
    acc_pdata_i   = '0;
    acc_perror_i  = 1'b0;
    rst_i         = 1'b1;

    // Reset state
    doReset();
    applyStimulus('0, 1'b1, 1'b0, '0, '1);
    checkOutput("rst_qvalid", PW'(acc_qvalid_o), PW'(1'b0));
    checkOutput("rst_rspvalid", PW'(rsp_valid_o), PW'(2'b00));
    checkOutput("rst_err", PW'(err_o), PW'(1'b0));
    checkOutput("rst_stall", PW'(stall_cnt_o), PW'(64'd0));

    // Single request from requester 1 and its response
    req_id_i[1]      = 5'h1A;
    req_payload_i[1] = Payload1;
    applyStimulus(2'b10, 1'b1, 1'b0, '0, '0);
    checkOutput("single_qvalid", PW'(acc_qvalid_o), PW'(1'b1));
    checkOutput("single_qid", PW'(acc_qid_o), PW'(5'd1));
    checkOutput("single_payload", acc_qpayload_o, Payload1);
    checkOutput("single_ready", PW'(req_ready_o), PW'(2'b10));
    nextCycle();
    acc_pdata_i  = 32'hDEADBEEF;
    acc_perror_i = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b1, 5'd1, 2'b10);
    checkOutput("single_rspvalid", PW'(rsp_valid_o), PW'(2'b10));
    checkOutput("single_rspid", PW'(rsp_id_o), PW'(5'h1A));
    checkOutput("single_pready", PW'(acc_pready_o), PW'(1'b1));
    checkOutput("single_rspdata", PW'(rsp_data_o), PW'(32'hDEADBEEF));
    checkOutput("single_rsperr", PW'(rsp_error_o), PW'(1'b1));
    nextCycle();
    acc_perror_i = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0, '0, '0);
    checkOutput("single_noerr", PW'(err_o), PW'(1'b0));

    // Fairness: both requesters valid for 8 cycles
    doReset();
    grants0 = 0;
    grants1 = 0;
    for (int k = 0; k < 8; k++) begin
      req_id_i[0] = IdWidth'(k);
      req_id_i[1] = IdWidth'(16 + k);
      applyStimulus(2'b11, 1'b1, 1'b0, '0, '0);
      checkOutput($sformatf("fair_qid%0d", k), PW'(acc_qid_o), PW'(k % 2));
      if (req_ready_o[0]) grants0++;
      if (req_ready_o[1]) grants1++;
      nextCycle();
    end
    checkOutput("fair_grants0", PW'(grants0), PW'(4));
    checkOutput("fair_grants1", PW'(grants1), PW'(4));
    applyStimulus(2'b11, 1'b1, 1'b0, '0, '0);
    checkOutput("fair_full_qvalid", PW'(acc_qvalid_o), PW'(1'b0));
    // Drain: ids must come back in issue order per requester
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, 1'b0, 1'b1, 5'd0, 2'b11);
      checkOutput($sformatf("drain0_id%0d", k), PW'(rsp_id_o), PW'(2 * k));
      nextCycle();
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, 1'b0, 1'b1, 5'd1, 2'b11);
      checkOutput($sformatf("drain1_id%0d", k), PW'(rsp_id_o), PW'(17 + 2 * k));
      nextCycle();
    end

    // Grant lock: requester 0 stalls while the pointer already favours 1
    doReset();
    req_payload_i[0] = PayloadA;
    req_payload_i[1] = PayloadB;
    applyStimulus(2'b01, 1'b1, 1'b0, '0, '0);
    nextCycle();
    applyStimulus(2'b01, 1'b0, 1'b0, '0, '0);
    checkOutput("lock_qid_first", PW'(acc_qid_o), PW'(5'd0));
    nextCycle();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(2'b11, 1'b0, 1'b0, '0, '0);
      checkOutput($sformatf("lock_qid%0d", c), PW'(acc_qid_o), PW'(5'd0));
      checkOutput($sformatf("lock_payload%0d", c), acc_qpayload_o, PayloadA);
      checkOutput($sformatf("lock_ready%0d", c), PW'(req_ready_o), PW'(2'b00));
      nextCycle();
    end
    applyStimulus(2'b11, 1'b1, 1'b0, '0, '0);
    checkOutput("lock_release_qid", PW'(acc_qid_o), PW'(5'd0));
    checkOutput("lock_release_ready", PW'(req_ready_o), PW'(2'b01));
    nextCycle();
    applyStimulus(2'b11, 1'b1, 1'b0, '0, '0);
    checkOutput("lock_next_qid", PW'(acc_qid_o), PW'(5'd1));
    checkOutput("lock_next_payload", acc_qpayload_o, PayloadB);

    // Outstanding limit on requester 0
    doReset();
    for (int k = 0; k < 4; k++) begin
      req_id_i[0] = IdWidth'(8 + k);
      applyStimulus(2'b01, 1'b1, 1'b0, '0, '0);
      checkOutput($sformatf("limit_issue%0d", k), PW'(req_ready_o), PW'(2'b01));
      nextCycle();
    end
    applyStimulus(2'b01, 1'b1, 1'b1, 5'd0, 2'b01);
    checkOutput("limit_full_ready", PW'(req_ready_o), PW'(2'b00));
    checkOutput("limit_full_qvalid", PW'(acc_qvalid_o), PW'(1'b0));
    checkOutput("limit_rspvalid", PW'(rsp_valid_o), PW'(2'b01));
    checkOutput("limit_rspid0", PW'(rsp_id_o), PW'(5'h08));
    nextCycle();
    req_id_i[0] = 5'h0C;
    applyStimulus(2'b01, 1'b1, 1'b1, 5'd0, 2'b01);
    checkOutput("limit_regain_ready", PW'(req_ready_o), PW'(2'b01));
    checkOutput("limit_rspid1", PW'(rsp_id_o), PW'(5'h09));
    nextCycle();
    req_id_i[0] = 5'h0D;
    applyStimulus(2'b01, 1'b1, 1'b0, '0, '0);
    checkOutput("limit_pushpop_ready", PW'(req_ready_o), PW'(2'b01));
    nextCycle();
    applyStimulus(2'b01, 1'b1, 1'b0, '0, '0);
    checkOutput("limit_refull_ready", PW'(req_ready_o), PW'(2'b00));
    applyStimulus(2'b00, 1'b0, 1'b1, 5'd0, 2'b01);
    checkOutput("limit_rspid2", PW'(rsp_id_o), PW'(5'h0A));

    // Response errors: out-of-range tag, then tag with nothing in flight
    doReset();
    applyStimulus(2'b00, 1'b0, 1'b1, 5'd3, 2'b00);
    checkOutput("err_oor_pready", PW'(acc_pready_o), PW'(1'b1));
    checkOutput("err_oor_rspvalid", PW'(rsp_valid_o), PW'(2'b00));
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b0, '0, '0);
    checkOutput("err_oor_set", PW'(err_o), PW'(1'b1));
    nextCycle();
    checkOutput("err_oor_sticky", PW'(err_o), PW'(1'b1));
    doReset();
    applyStimulus(2'b00, 1'b0, 1'b0, '0, '0);
    checkOutput("err_cleared", PW'(err_o), PW'(1'b0));
    applyStimulus(2'b00, 1'b0, 1'b1, 5'd0, 2'b00);
    checkOutput("err_empty_pready", PW'(acc_pready_o), PW'(1'b1));
    checkOutput("err_empty_rspvalid", PW'(rsp_valid_o), PW'(2'b00));
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b0, '0, '0);
    checkOutput("err_empty_set", PW'(err_o), PW'(1'b1));

    // Stall counter: requester 1 held off for 10 cycles
    doReset();
    applyStimulus(2'b10, 1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 10; c++) nextCycle();
`ifdef SNAX_ACC_ARB_PERF_EN
    stallExp = 32'd10;
`else
    stallExp = 32'd0;
`endif
    checkOutput("stall_cnt1", PW'(stall_cnt_o[1]), PW'(stallExp));
    checkOutput("stall_cnt0", PW'(stall_cnt_o[0]), PW'(32'd0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/snax_acc_offload_arbiter.md
# snax_acc_offload_arbiter

Round-robin arbiter that shares one Snitch accelerator offload port (acc q/p channels) between `NumReq` requesters, such as several cores or a core plus a DMA-driven configurator, in a SNAX shell. It tags each issued request with the requester index in the `id` field and stores the original `id` in a per-requester FIFO. Responses are routed back by tag with the original `id` restored. A per-requester outstanding limit and back-pressure keep the accelerator from being flooded.

## Interface
- `NumReq`, 2: number of requesters (2..8).
- `IdWidth`, 5: width of the acc `id` field; must satisfy `$clog2(NumReq) <= IdWidth`.
- `PayloadWidth`, 32+32+32+48+32: opaque request payload: addr, data_op, arga, argb, argc.
- `DataWidth`, 32: response data width.
- `MaxOutstanding`, 4: maximum in-flight requests per requester (power of two, ≥1).

- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NumReq  per-requester request valid.
- `req_ready_o`  out  NumReq  per-requester request ready.
- `req_id_i`  in  NumReq×IdWidth  requester-local id.
- `req_payload_i`  in  NumReq×PayloadWidth  request payload.
- `acc_qvalid_o`  out  1  shared request valid.
- `acc_qready_i`  in  1  shared request ready.
- `acc_qid_o`  out  IdWidth  tag: granted index, zero-extended.
- `acc_qpayload_o`  out  PayloadWidth  granted payload.
- `acc_pvalid_i`  in  1  response valid.
- `acc_pready_o`  out  1  response ready.
- `acc_pid_i`  in  IdWidth  response tag.
- `acc_pdata_i`  in  DataWidth  response data.
- `acc_perror_i`  in  1  response error.
- `rsp_valid_o`  out  NumReq  routed response valid.
- `rsp_ready_i`  in  NumReq  routed response ready.
- `rsp_id_o`  out  IdWidth  restored original id (shared bus).
- `rsp_data_o`  out  DataWidth  response data (shared bus).
- `rsp_error_o`  out  1  response error (shared bus).
- `err_o`  out  1  sticky protocol error.
- `stall_cnt_o`  out  NumReq×32  per-requester stall counters (see Configuration).

## Operation
- Eligibility: requester i is eligible when `req_valid_i[i]` is high and `out_cnt[i] < MaxOutstanding`.
- Arbitration: round-robin, starting the search at pointer `rr_ptr`. The winner drives `acc_q*`. `req_ready_o[i] = grant[i] & acc_qready_i`.
- Grant lock: if `acc_qvalid_o` is high and `acc_qready_i` is low, `lock` is set and the grant is held on the same requester until the handshake completes. Payload and tag remain stable.
- On a q handshake by requester i:
  - `rr_ptr` ← (i+1) mod NumReq.
  - `req_id_i[i]` is pushed into `id_fifo[i]` (depth MaxOutstanding).
  - `out_cnt[i]` increments.
- Response routing:
  - `idx = acc_pid_i[$clog2(NumReq)-1:0]`.
  - `rsp_valid_o[idx] = acc_pvalid_i`.
  - `acc_pready_o = rsp_ready_i[idx]`.
  - `rsp_id_o` = head of `id_fifo[idx]`.
  - Data and error pass through.
- On a p handshake: pop `id_fifo[idx]` and decrement `out_cnt[idx]`.
- Simultaneous issue and response for the same requester: FIFO push and pop both occur; `out_cnt` is unchanged.
- Response errors: a response whose tag is ≥NumReq, or whose tag names a requester with `out_cnt`=0:
  - `acc_pready_o`=1, so the response is dropped.
  - No `rsp_valid_o` is asserted.
  - `err_o` is set; it clears only on reset.
- Responses for one requester must return in issue order; the accelerator guarantees this per tag.

## Timing
- Request path is combinational, 0-cycle: `req_valid_i` → `acc_qvalid_o`, and `acc_qready_i` → `req_ready_o`.
- Response path is combinational, 0-cycle.
- State updates on `clk_i` rising edge: `rr_ptr`, `lock`, `out_cnt`, FIFOs.
- Reset values:
  - State: `rr_ptr`=0, `lock`=0, all `out_cnt`=0, FIFOs empty, `err_o`=0, stall counters 0.
  - Outputs therefore drive: `acc_qvalid_o`=0 absent requests, `rsp_valid_o`=0 absent responses.
- Reset mid-transaction: all in-flight bookkeeping is discarded. The accelerator must be reset concurrently.
- A requester at `out_cnt`=MaxOutstanding regains eligibility in the cycle after its response handshake.
- Full throughput: one issue per cycle, plus one response per cycle.

## Configuration
- `SNAX_ACC_ARB_PERF_EN` defined:
  - Per-requester 32-bit saturating counter increments each cycle with `req_valid_i[i] & ~req_ready_o[i]`.
  - Counters saturate at 0xFFFF_FFFF and clear on reset.
- Not defined: `stall_cnt_o` is tied to 0 and no counter flops are instantiated.

## Test plan
- Single request, NumReq=2: requester 1 sends id 0x1A with `acc_qready_i`=1 → `acc_qid_o`=1 the same cycle. A response with tag 1 → `rsp_valid_o`=2'b10 and `rsp_id_o`=0x1A.
- Fairness: both requesters hold valid for 8 cycles with ready=1 → grants alternate 0,1,0,1…, exactly 4 each.
- Lock: requester 0 is granted with `acc_qready_i`=0 for 3 cycles while requester 1 raises valid → the grant, tag 0 and payload stay stable until the handshake. Requester 1 is granted next.
- Outstanding limit: requester 0 issues 4 requests with no responses → `req_ready_o[0]`=0 on the 5th. It is re-accepted in the cycle after one tag-0 response handshake.
- Response errors:
  - A response with tag 3 when NumReq=2 → `acc_pready_o`=1, no `rsp_valid_o`, `err_o`=1 until `rst_i`.
  - A response with tag 0 when `out_cnt[0]`=0 → same.
- With `SNAX_ACC_ARB_PERF_EN`: hold requester 1 valid with `acc_qready_i`=0 for 10 cycles → `stall_cnt_o[1]`=10. Without the macro → `stall_cnt_o`=0.
